// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg -- shared types and constants for the serial-parallel multiplier.
//
// Contents:
//   spm_state_t    control FSM state encoding (IDLE, LOAD, RUN, FIN)
//   clog2()        ceiling log2, used to size the product-bit counter
//   SPM_MAX_WIDTH  largest legal operand width
//   SPM_SIGNED     1 when built with SPM_MULT_SIGNED_EN (two's complement
//                  operands), 0 for the default unsigned build
// -----------------------------------------------------------------------------
package spm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } spm_state_t;

   localparam int SPM_MAX_WIDTH = 32;

`ifdef SPM_MULT_SIGNED_EN
   localparam bit SPM_SIGNED = 1'b1;
`else
   localparam bit SPM_SIGNED = 1'b0;
`endif

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/spm_mult_cell.sv
// -----------------------------------------------------------------------------
// spm_csa_cell -- one bit-slice of the serial-parallel multiplier chain.
//
// Forms the partial product i_x & i_y, adds it to the sum arriving from the
// next-more-significant slice and to this slice's own carry, and registers the
// new sum and carry. The registered sum is handed to the next-less-significant
// slice.
//
// Parameter IS_MSB marks the most significant slice. In the signed build
// (SPM_MULT_SIGNED_EN) that slice is the TCMP cell: its partial-product stream
// is negated serially (copy bits up to and including the first 1, invert the
// rest), which gives x's sign bit its negative weight. In the unsigned build
// every slice is a plain carry-save adder.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_clr      synchronous clear of sum/carry/negation state (new operation)
//   i_en       advance one step (consume one multiplier bit)
//   i_x        multiplicand bit held by this slice
//   i_y        current serial multiplier bit
//   i_sum_in   registered sum of the next-more-significant slice
//   o_sum      this slice's registered sum
// -----------------------------------------------------------------------------
module spm_csa_cell
   import spm_pkg::*;
#(
   parameter bit IS_MSB = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_x,
   input  logic i_y,
   input  logic i_sum_in,
   output logic o_sum
);

   logic       r_sum;
   logic       r_carry;
   logic       r_neg;     // serial negation: set once a 1 has passed through
   logic       w_pp_raw;
   logic       w_pp;
   logic [1:0] w_add;

   assign w_pp_raw = i_x & i_y;
   assign w_pp     = (IS_MSB && SPM_SIGNED) ? (w_pp_raw ^ r_neg) : w_pp_raw;
   assign w_add    = {1'b0, w_pp} + {1'b0, i_sum_in} + {1'b0, r_carry};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum   <= 1'b0;
         r_carry <= 1'b0;
         r_neg   <= 1'b0;
      end else if (i_clr) begin
         r_sum   <= 1'b0;
         r_carry <= 1'b0;
         r_neg   <= 1'b0;
      end else if (i_en) begin
         r_sum   <= w_add[0];
         r_carry <= w_add[1];
         r_neg   <= r_neg | w_pp_raw;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/spm_mult.sv
// -----------------------------------------------------------------------------
// spm_mult -- parametrised serial-parallel multiplier.
//
// x is held in parallel across a chain of WIDTH carry-save cells; y is shifted
// in LSB first and one product bit leaves the least significant cell per
// cycle. A full 2*WIDTH-bit product is assembled in an accumulator.
//
// Build option: define SPM_MULT_SIGNED_EN for two's complement operands and
// product (y is sign-extended after its WIDTH bits, the MSB cell is TCMP).
// Default build is unsigned with zero fill.
//
// Handshake: start is accepted on a rising edge where busy is low (IDLE or the
// FIN cycle); x and y are latched on that edge and busy rises in the next
// cycle. start while busy is high is ignored. done pulses for one cycle, with
// busy low, and product is valid from that cycle until the next done.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request
//   x, y              operands, latched on an accepted start
//   busy              operation in progress (LOAD and RUN)
//   done              one-cycle completion pulse (FIN)
//   product           2*WIDTH-bit result, held until the next done
//   prod_bit          serial product bit, LSB first
//   prod_bit_vld      qualifies prod_bit, 2*WIDTH cycles per operation
// -----------------------------------------------------------------------------
module spm_mult
   import spm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 prod_bit,
   output logic                 prod_bit_vld
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = clog2(2 * WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PW - 1);

   if (WIDTH < 2 || WIDTH > SPM_MAX_WIDTH) begin : g_bad_width
      $error("spm_mult: WIDTH out of range");
   end

   spm_state_t       r_state;
   spm_state_t       w_next;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y_sh;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-2:0]    r_acc;      // bits 0..PW-2; the last bit joins at FIN entry
   logic [PW-1:0]    r_product;
   logic [WIDTH:0]   w_sum;      // w_sum[i] = registered sum of cell i
   logic             w_accept;
   logic             w_cell_en;
   logic             w_last;
   logic             w_fill;

   assign w_accept  = start && ((r_state == IDLE) || (r_state == FIN));
   // Cells step in LOAD as well, so the first product bit is already waiting
   // in cell 0 when RUN begins.
   assign w_cell_en = (r_state == LOAD) || (r_state == RUN);
   assign w_last    = (r_state == RUN) && (r_cnt == LAST_CNT);
   // After WIDTH shifts y_sh holds only fill bits: zeros, or copies of y's
   // sign bit in the signed build.
   assign w_fill    = SPM_SIGNED ? r_y_sh[WIDTH-1] : 1'b0;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      prod_bit_vld = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = LOAD;
         end
         LOAD: begin
            busy   = 1'b1;
            w_next = RUN;
         end
         RUN: begin
            busy         = 1'b1;
            prod_bit_vld = 1'b1;
            if (r_cnt == LAST_CNT) w_next = FIN;
         end
         FIN: begin
            done   = 1'b1;
            w_next = start ? LOAD : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x       <= '0;
         r_y_sh    <= '0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_product <= '0;
      end else begin
         if (w_accept) begin
            r_x    <= x;
            r_y_sh <= y;
            r_acc  <= '0;
         end else begin
            if (w_cell_en) r_y_sh <= {w_fill, r_y_sh[WIDTH-1:1]};
            if (r_state == RUN) r_acc <= {w_sum[0], r_acc[PW-2:1]};
         end

         if (r_state == LOAD)     r_cnt <= '0;
         else if (r_state == RUN) r_cnt <= r_cnt + 1'b1;

         // Final bit is the one on prod_bit this cycle; product is therefore
         // complete and stable throughout the FIN (done) cycle.
         if (w_last) r_product <= {w_sum[0], r_acc};
      end
   end

   // ---------------- cell chain ----------------
   assign w_sum[WIDTH] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      spm_csa_cell #(
         .IS_MSB (i == WIDTH - 1)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .i_clr    (w_accept),
         .i_en     (w_cell_en),
         .i_x      (r_x[i]),
         .i_y      (r_y_sh[0]),
         .i_sum_in (w_sum[i+1]),
         .o_sum    (w_sum[i])
      );
   end

   assign product  = r_product;
   assign prod_bit = prod_bit_vld & w_sum[0];

endmodule

// File: tb/tb_spm_mult.sv
// -----------------------------------------------------------------------------
// tb_spm_mult -- self-checking bench for spm_mult at WIDTH=8 and WIDTH=16.
// Follows SPM_MULT_SIGNED_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spm_mult;

   localparam int W8  = 8;
   localparam int W16 = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;   // number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- DUTs ----------------
   logic          start8, busy8, done8, pbit8, pvld8;
   logic [7:0]    x8, y8;
   logic [15:0]   prod8;
   logic          start16, busy16, done16, pbit16, pvld16;
   logic [15:0]   x16, y16;
   logic [31:0]   prod16;

   spm_mult #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
      .busy(busy8), .done(done8), .product(prod8),
      .prod_bit(pbit8), .prod_bit_vld(pvld8)
   );

   spm_mult #(.WIDTH(W16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .x(x16), .y(y16),
      .busy(busy16), .done(done16), .product(prod16),
      .prod_bit(pbit16), .prod_bit_vld(pvld16)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] lo_mask, ea, eb, r;
      lo_mask = (64'd1 << w) - 64'd1;
      ea = {32'd0, a} & lo_mask;
      eb = {32'd0, b} & lo_mask;
`ifdef SPM_MULT_SIGNED_EN
      if (ea[w-1]) ea = ea | ~lo_mask;
      if (eb[w-1]) eb = eb | ~lo_mask;
`endif
      r = ea * eb;
      return r & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard queues ----------------
   logic [15:0] exp8_q[$];
   int          acc8_q[$];
   int          nf8 = 0;     // first edge at which dut8 may accept again
   logic [31:0] exp16_q[$];
   int          acc16_q[$];
   int          nf16 = 0;

   // ---------------- driver tasks ----------------
   // One call = one clock cycle of stimulus; the edge after the call samples it.
   task automatic drive8(input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic took);
      @(posedge clk); #1;
      start8 = s; x8 = a; y8 = b;
      took = 1'b0;
      if (s && (cyc + 1 >= nf8)) begin
         took = 1'b1;
         exp8_q.push_back(16'(ref_mul(W8, 32'(a), 32'(b))));
         acc8_q.push_back(cyc + 1);
         nf8 = cyc + 1 + 2 * W8 + 2;
      end
   endtask

   task automatic drive16(input logic s, input logic [15:0] a, input logic [15:0] b,
                          output logic took);
      @(posedge clk); #1;
      start16 = s; x16 = a; y16 = b;
      took = 1'b0;
      if (s && (cyc + 1 >= nf16)) begin
         took = 1'b1;
         exp16_q.push_back(32'(ref_mul(W16, 32'(a), 32'(b))));
         acc16_q.push_back(cyc + 1);
         nf16 = cyc + 1 + 2 * W16 + 2;
      end
   endtask

   task automatic idle8();
      logic tk;
      while (cyc < nf8 + 2) drive8(1'b0, 8'($urandom), 8'($urandom), tk);
   endtask

   task automatic idle16();
      logic tk;
      while (cyc < nf16 + 2) drive16(1'b0, 16'($urandom), 16'($urandom), tk);
   endtask

   // ---------------- monitors ----------------
   logic [63:0] bits8, bits16;
   int          nb8, bz8, nb16, bz16;

   always @(negedge clk) begin
      if (rst) begin
         bits8 = '0; nb8 = 0; bz8 = 0;
      end else begin
         if (busy8) bz8++;
         if (pvld8) begin
            if (nb8 < 64) bits8[nb8] = pbit8;
            nb8++;
         end
         if (done8) begin
            if (exp8_q.size() == 0) begin
               check("done8_unexpected", 64'(done8), 64'd0);
            end else begin
               logic [15:0] e;
               int          a;
               e = exp8_q.pop_front();
               a = acc8_q.pop_front();
               check("product8", 64'(prod8), 64'(e));
               check("bitstream8", bits8, 64'(e));
               check("vld_cycles8", 64'(nb8), 64'(2 * W8));
               check("latency8", 64'(cyc + 1 - a), 64'(2 * W8 + 2));
               check("busy_cycles8", 64'(bz8), 64'(2 * W8 + 1));
            end
            bits8 = '0; nb8 = 0; bz8 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         bits16 = '0; nb16 = 0; bz16 = 0;
      end else begin
         if (busy16) bz16++;
         if (pvld16) begin
            if (nb16 < 64) bits16[nb16] = pbit16;
            nb16++;
         end
         if (done16) begin
            if (exp16_q.size() == 0) begin
               check("done16_unexpected", 64'(done16), 64'd0);
            end else begin
               logic [31:0] e;
               int          a;
               e = exp16_q.pop_front();
               a = acc16_q.pop_front();
               check("product16", 64'(prod16), 64'(e));
               check("bitstream16", bits16, 64'(e));
               check("vld_cycles16", 64'(nb16), 64'(2 * W16));
               check("latency16", 64'(cyc + 1 - a), 64'(2 * W16 + 2));
               check("busy_cycles16", 64'(bz16), 64'(2 * W16 + 1));
            end
            bits16 = '0; nb16 = 0; bz16 = 0;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      logic tk;
      rst = 1'b1;
      start8 = 1'b0; x8 = '0; y8 = '0;
      start16 = 1'b0; x16 = '0; y16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_done8", 64'(done8), 64'd0);
      check("rst_product8", 64'(prod8), 64'd0);
      check("rst_pbit8", 64'(pbit8), 64'd0);
      check("rst_vld8", 64'(pvld8), 64'd0);
      check("rst_busy16", 64'(busy16), 64'd0);
      check("rst_product16", 64'(prod16), 64'd0);
      rst = 1'b0;

      // directed operands, including all-ones, zero and signed corner values
      drive8(1'b1, 8'd200, 8'd150, tk); idle8();
      drive8(1'b1, 8'hFF, 8'hFF, tk);   idle8();
      drive8(1'b1, 8'h00, 8'hAB, tk);   idle8();
      drive8(1'b1, 8'h80, 8'h80, tk);   idle8();
      drive8(1'b1, 8'hFF, 8'h7F, tk);   idle8();
      drive8(1'b1, 8'hFB, 8'h06, tk);   idle8();

      // start held every cycle: only the first and the FIN-cycle one are taken
      drive8(1'b1, 8'd3, 8'd5, tk);
      for (int i = 0; i < 40; i++) begin
         drive8(1'b1, 8'd7, 8'd9, tk);
         if (tk) break;
      end
      drive8(1'b0, 8'd0, 8'd0, tk);
      idle8();

      // reset in RUN at counter 5
      drive8(1'b1, 8'd99, 8'd77, tk);
      repeat (6) drive8(1'b0, 8'($urandom), 8'($urandom), tk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_busy8", 64'(busy8), 64'd0);
      check("midrst_done8", 64'(done8), 64'd0);
      check("midrst_product8", 64'(prod8), 64'd0);
      check("midrst_vld8", 64'(pvld8), 64'd0);
      check("midrst_pbit8", 64'(pbit8), 64'd0);
      exp8_q.delete(); acc8_q.delete(); nf8 = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      drive8(1'b1, 8'd12, 8'd12, tk); idle8();

      // random stream with start pulses landing anywhere, including while busy
      repeat (600)
         drive8(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), tk);
      drive8(1'b0, 8'd0, 8'd0, tk);
      idle8();

      // wider build
      drive16(1'b1, 16'hFFFF, 16'hFFFF, tk); idle16();
      drive16(1'b1, 16'h8000, 16'h8000, tk); idle16();
      repeat (300)
         drive16(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), tk);
      drive16(1'b0, 16'd0, 16'd0, tk);
      idle16();

      check("pending8", 64'(exp8_q.size()), 64'd0);
      check("pending16", 64'(exp16_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spm_mult.md
Name: spm_mult

Overview:
Parametrised serial-parallel multiplier. It is the successor of the fixed 8-bit SPM.
- x is held in parallel; y is shifted in LSB-first.
- A chain of carry-save adder cells emits one product bit per cycle, LSB first.
- Adds a start/busy/done handshake, WIDTH generalisation, and a serial-bit tap.
- Sits beside the datapath as a low-area multiplier for non-critical arithmetic.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; the product is 2*WIDTH bits.
CNT_W, $clog2(2*WIDTH)+1, localparam width of the bit counter; not overridable.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy==0.
x  input  WIDTH  multiplicand; latched on an accepted start.
y  input  WIDTH  multiplier; latched on an accepted start.
busy  output  1  high while a multiplication is in progress.
done  output  1  one-cycle pulse; product is valid from this cycle.
product  output  2*WIDTH  final product; held until the next done.
prod_bit  output  1  serial product bit, LSB first.
prod_bit_vld  output  1  qualifies prod_bit; high for exactly 2*WIDTH cycles per operation.

Behaviour:
- Reset (asynchronous): busy=0, done=0, product=0, prod_bit=0, prod_bit_vld=0. All cell sum/carry flops, the counter and the operand registers clear. FSM goes to IDLE.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE: on start=1, latch x and y, clear all cells and the accumulator, go to LOAD, busy=1 from the next cycle.
- LOAD: one cycle to prime the y shift register. Go to RUN with counter=0.
- RUN, each cycle:
  - the cell chain consumes y_sh[0]; y_sh shifts right;
  - prod_bit_vld=1 and prod_bit = bit[counter] of the product;
  - that bit is shifted into the MSB of the accumulator, and the accumulator shifts right;
  - counter increments.
- Zero fill: after WIDTH cycles, y_sh feeds 0 (unsigned build) so the carries flush.
- Exit from RUN: when counter==2*WIDTH-1, go to FIN.
- FIN:
  - product<=accumulator, done=1 for one cycle, busy=0 in the same cycle;
  - no post-shift correction of any kind;
  - next state is IDLE, or LOAD if start=1 (back-to-back accepted in the FIN cycle).
- Latency: done is asserted exactly 2*WIDTH+2 rising edges after the edge that accepted start. For WIDTH=8 this is 18 edges.
- start while busy=1 is ignored and has no side effects.
- x and y may change freely after acceptance; only the latched copies are used.
- Reset mid-operation: outputs go to reset values immediately. The previous product is lost (product=0).
- Cell chain:
  - x[WIDTH-1] uses the TCMP-type cell;
  - x[WIDTH-2..0] use CSADD-type cells;
  - each cell's partial product is x[i] & y_sh[0];
  - each cell holds its own sum and carry flop.
- Arithmetic:
  - full 2*WIDTH-bit result, no truncation or saturation;
  - unsigned build: 0*anything = 0;
  - (2^W-1)^2 = 2^(2W) - 2^(W+1) + 1.

Optional Feature:
SPM_MULT_SIGNED_EN
- Defined: operands and product are two's complement.
  - For cycles WIDTH..2*WIDTH-1, y_sh feeds y[WIDTH-1] (sign extension) instead of 0.
  - The TCMP-type MSB cell complements and handles negative weight so the 2*WIDTH-bit result is the correct signed product.
  - Latency is unchanged.
- Undefined: unsigned operands; zero fill; the MSB cell behaves as a plain CSADD cell.

Decomposition:
- Package spm_pkg:
  - state enum (IDLE, LOAD, RUN, FIN);
  - function clog2 for CNT_W;
  - constant SPM_MAX_WIDTH=32.
- Sub-module spm_csa_cell:
  - one bit-slice (AND partial product, full adder, sum and carry flops, async clear);
  - parameter IS_MSB selects the TCMP behaviour;
  - instantiated WIDTH times in a generate loop.

Test Plan:
- WIDTH=8, unsigned, x=200, y=150, single start -> done on edge 18, product=0x7530, prod_bit stream LSB-first matches 0x7530 across 16 vld cycles.
- WIDTH=8, x=255, y=255 -> product=0xFE01; x=0, y=0xAB -> product=0x0000; busy high for exactly 17 cycles.
- start pulses every cycle during a run with x=3, y=5 and then x=7, y=9 -> only the first is taken, product=15; the FIN-cycle start is accepted back-to-back and gives product=63, 18 edges later.
- Assert rst at RUN counter=5 -> busy, done, product, prod_bit_vld all 0 asynchronously. A fresh start x=12, y=12 then gives 144.
- WIDTH=16, x=0xFFFF, y=0xFFFF -> product=0xFFFE0001, done on edge 34.
- SPM_MULT_SIGNED_EN, WIDTH=8:
  - x=-128, y=-128 -> 0x4000;
  - x=-1, y=127 -> 0xFF81;
  - x=-5, y=6 -> 0xFFE2.
